// File: rtl/int_alu_issue_arb.sv
// Round-robin issue arbiter in front of the shared integer ALU.
// Divide/remainder ops occupy the ALU for DIV_LAT cycles; all other ops respond on the next cycle.
module int_alu_issue_arb #(
  parameter int NUM_REQ = 4,
  parameter int DIV_LAT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0][7:0] req_op,
  input  logic [NUM_REQ-1:0][4:0] req_warp,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    flush,
  output logic [7:0]              alu_op,
  output logic [4:0]              alu_warp,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    busy,
  output logic [15:0]             issue_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DIV_LAT);
  // Opcode values shared with simt_pkg::opcode_e
  localparam logic [7:0] OP_IDIV = 8'h05;
  localparam logic [7:0] OP_IREM = 8'h06;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LAT - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_r, state_n_s;
  logic [CNT_W-1:0] cnt_r, cnt_n_s;
  logic [IDX_W-1:0] last_grant_r;
  logic [IDX_W-1:0] winner_s;
  logic             found_s;
  logic             grant_ok_s;
  logic             grant_s;
  logic             win_is_div_s;
  logic [7:0]       alu_op_r;
  logic [4:0]       alu_warp_r;
  logic [15:0]      issue_count_r;

  // Round-robin search upward from the requester after the last winner
  always_comb begin
    logic [IDX_W-1:0] idx_v;
    logic             hit_v;
    found_s  = 1'b0;
    winner_s = last_grant_r;
    idx_v    = last_grant_r;
    hit_v    = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_v    = IDX_W'((int'(last_grant_r) + k) % NUM_REQ);
      hit_v    = !found_s && req_valid[idx_v];
      winner_s = hit_v ? idx_v : winner_s;
      found_s  = found_s | hit_v;
    end
  end

  // Grants are held off during reset, on flush, and while a result is unclaimed
  assign grant_ok_s   = !rst && !flush &&
                        ((state_r == IDLE) || ((state_r == RESP) && res_ready));
  assign grant_s      = grant_ok_s && found_s;
  assign win_is_div_s = (req_op[winner_s] == OP_IDIV) || (req_op[winner_s] == OP_IREM);
  assign req_ready    = grant_s ? (NUM_REQ'(1) << winner_s) : {NUM_REQ{1'b0}};

  // Next-state and divide-latency counter logic
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    if (flush) begin
      state_n_s = IDLE;
      cnt_n_s   = '0;
    end else begin
      case (state_r)
        IDLE, RESP: begin
          if (grant_s) begin
            if (win_is_div_s) begin
              state_n_s = EXEC;
              cnt_n_s   = CNT_LOAD;
            end else begin
              state_n_s = RESP;
            end
          end else if ((state_r == RESP) && res_ready) begin
            state_n_s = IDLE;
          end else begin
            state_n_s = state_r;
          end
        end
        EXEC: begin
          if (cnt_r == '0) begin
            state_n_s = RESP;
          end else begin
            cnt_n_s = cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_n_s = IDLE;
          cnt_n_s   = '0;
        end
      endcase
    end
  end

  // State register and counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n_s;
      cnt_r   <= cnt_n_s;
    end
  end

  // Operation capture on grant; flush leaves these untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r  <= LAST_RST;
      alu_op_r      <= 8'h00;
      alu_warp_r    <= 5'd0;
      issue_count_r <= 16'h0000;
    end else if (grant_s) begin
      last_grant_r  <= winner_s;
      alu_op_r      <= req_op[winner_s];
      alu_warp_r    <= req_warp[winner_s];
      issue_count_r <= issue_count_r + 16'd1;
    end else begin
      last_grant_r  <= last_grant_r;
      alu_op_r      <= alu_op_r;
      alu_warp_r    <= alu_warp_r;
      issue_count_r <= issue_count_r;
    end
  end

  assign alu_op      = alu_op_r;
  assign alu_warp    = alu_warp_r;
  assign issue_count = issue_count_r;
  assign res_valid   = (state_r == RESP);
  assign busy        = (state_r != IDLE);

endmodule

// File: tb/tb_int_alu_issue_arb.sv
// Scenario bench for int_alu_issue_arb: a reference round-robin model predicts each grant
// and queues the expected ALU operation, which is compared when the result is presented.
module tb_int_alu_issue_arb;

  localparam int N  = 4;
  localparam int DL = 8;
  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_SUB  = 8'h01;
  localparam logic [7:0] OP_IDIV = 8'h05;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid;
  logic [N-1:0][7:0]   req_op;
  logic [N-1:0][4:0]   req_warp;
  logic [N-1:0]        req_ready;
  logic                flush;
  logic [7:0]          alu_op;
  logic [4:0]          alu_warp;
  logic                res_valid;
  logic                res_ready;
  logic                busy;
  logic [15:0]         issue_count;

  int          checks = 0;
  int          failures = 0;
  int          m_last;
  logic [15:0] m_count;

  typedef struct packed {
    logic [7:0] op;
    logic [4:0] warp;
  } res_t;
  res_t exp_q[$];

  always #5 clk = ~clk;

  int_alu_issue_arb #(.NUM_REQ(N), .DIV_LAT(DL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_warp(req_warp),
    .req_ready(req_ready), .flush(flush), .alu_op(alu_op), .alu_warp(alu_warp),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .issue_count(issue_count)
  );

  function automatic int pick(int last, logic [N-1:0] v);
    logic [1:0] ix;
    for (int k = 1; k <= N; k++) begin
      ix = 2'((last + k) % N);
      if (v[ix]) return int'(ix);
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] r;
    logic [1:0]   ix;
    r = '0;
    if (i >= 0) begin
      ix = 2'(i);
      r[ix] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_grant(int w);
    logic [1:0] ix;
    ix = 2'(w);
    exp_q.push_back({req_op[ix], req_warp[ix]});
    m_last  = w;
    m_count = m_count + 16'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; res_ready = 1'b0; req_valid = '1;
    for (int i = 0; i < N; i++) begin
      req_op[i]   = OP_ADD;
      req_warp[i] = 5'(i + 10);
    end
    #12;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_flags got rv=%b busy=%b exp 0 0", res_valid, busy); end
    checks++; if (issue_count !== 16'h0000 || alu_op !== 8'h00 || alu_warp !== 5'd0) begin
      failures++; $display("FAIL reset_regs got cnt=%h op=%h warp=%h exp 0", issue_count, alu_op, alu_warp); end
    @(negedge clk);
    rst = 1'b0; req_valid = '0; m_last = N - 1; m_count = 16'h0000;
    #1;
    checks++; if (req_ready !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL idle_noreq got ready=%b busy=%b exp 0000 0", req_ready, busy); end
  endtask

  task automatic test_round_robin();
    res_t e;
    int   w;
    logic exp_rv;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_valid = (c < 5) ? 4'b1111 : 4'b0000;
      res_ready = 1'b1;
      #1;
      exp_rv = (c >= 1);
      checks++; if (res_valid !== exp_rv) begin failures++; $display("FAIL rr_res_valid c%0d got=%b exp=%b", c, res_valid, exp_rv); end
      if (c >= 1) begin
        e = exp_q.pop_front();
        checks++; if (alu_op !== e.op || alu_warp !== e.warp) begin
          failures++; $display("FAIL rr_result c%0d got op=%h warp=%0d exp op=%h warp=%0d", c, alu_op, alu_warp, e.op, e.warp); end
      end
      w = pick(m_last, req_valid);
      checks++; if (req_ready !== onehot(w)) begin failures++; $display("FAIL rr_grant c%0d got=%b exp=%b", c, req_ready, onehot(w)); end
      if (w >= 0) model_grant(w);
    end
    @(negedge clk); #1;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rr_idle got rv=%b busy=%b exp 0 0", res_valid, busy); end
    checks++; if (issue_count !== m_count) begin failures++; $display("FAIL rr_count got=%0d exp=%0d", issue_count, m_count); end
  endtask

  task automatic test_idiv();
    res_t e;
    int   w;
    logic exp_rv;
    @(negedge clk);
    req_valid = 4'b0100; req_op[2] = OP_IDIV; req_warp[2] = 5'd7; res_ready = 1'b1;
    #1;
    w = pick(m_last, req_valid);
    checks++; if (req_ready !== onehot(w)) begin failures++; $display("FAIL div_grant got=%b exp=%b", req_ready, onehot(w)); end
    if (w >= 0) model_grant(w);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      exp_rv = (n == 9);
      checks++; if (res_valid !== exp_rv) begin failures++; $display("FAIL div_latency n%0d got=%b exp=%b", n, res_valid, exp_rv); end
      checks++; if (alu_warp !== 5'd7 || busy !== 1'b1) begin failures++; $display("FAIL div_hold n%0d got warp=%0d busy=%b exp 7 1", n, alu_warp, busy); end
      if (n == 9) begin
        e = exp_q.pop_front();
        checks++; if (alu_op !== e.op || alu_warp !== e.warp) begin
          failures++; $display("FAIL div_result got op=%h warp=%0d exp op=%h warp=%0d", alu_op, alu_warp, e.op, e.warp); end
      end
    end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL div_idle got busy=%b exp 0", busy); end
    req_op[2] = OP_ADD;
  endtask

  task automatic test_stall();
    res_t e;
    int   w;
    @(negedge clk);
    req_valid = 4'b1000; req_op[3] = OP_SUB; res_ready = 1'b0;
    #1;
    w = pick(m_last, req_valid);
    checks++; if (req_ready !== onehot(w)) begin failures++; $display("FAIL stall_grant got=%b exp=%b", req_ready, onehot(w)); end
    if (w >= 0) model_grant(w);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      req_valid = 4'b0010; res_ready = 1'b0;
      #1;
      checks++; if (res_valid !== 1'b1 || req_ready !== 4'b0000) begin
        failures++; $display("FAIL stall_hold n%0d got rv=%b ready=%b exp 1 0000", n, res_valid, req_ready); end
    end
    @(negedge clk);
    res_ready = 1'b1;
    #1;
    e = exp_q.pop_front();
    checks++; if (res_valid !== 1'b1 || alu_op !== e.op || alu_warp !== e.warp) begin
      failures++; $display("FAIL stall_result got rv=%b op=%h warp=%0d exp 1 op=%h warp=%0d", res_valid, alu_op, alu_warp, e.op, e.warp); end
    w = pick(m_last, req_valid);
    checks++; if (req_ready !== onehot(w)) begin failures++; $display("FAIL b2b_grant got=%b exp=%b", req_ready, onehot(w)); end
    if (w >= 0) model_grant(w);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    e = exp_q.pop_front();
    checks++; if (res_valid !== 1'b1 || alu_op !== e.op || alu_warp !== e.warp) begin
      failures++; $display("FAIL b2b_result got rv=%b op=%h warp=%0d exp 1 op=%h warp=%0d", res_valid, alu_op, alu_warp, e.op, e.warp); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0 || issue_count !== m_count) begin
      failures++; $display("FAIL stall_end got busy=%b cnt=%0d exp 0 %0d", busy, issue_count, m_count); end
  endtask

  task automatic test_flush();
    int w;
    @(negedge clk);
    req_valid = 4'b0001; req_op[0] = OP_IDIV; res_ready = 1'b1;
    #1;
    w = pick(m_last, req_valid);
    checks++; if (req_ready !== onehot(w)) begin failures++; $display("FAIL flush_grant got=%b exp=%b", req_ready, onehot(w)); end
    if (w >= 0) begin
      model_grant(w);
      void'(exp_q.pop_back());
    end
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      req_valid = (n == 5) ? 4'b0010 : 4'b0000;
      flush     = (n == 4 || n == 5);
      #1;
      if (n == 4) begin
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_exec got busy=%b exp 1", busy); end
      end else if (n == 5) begin
        checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 4'b0000) begin
          failures++; $display("FAIL flush_abort got busy=%b rv=%b ready=%b exp 0 0 0000", busy, res_valid, req_ready); end
      end else if (n == 6) begin
        checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || issue_count !== m_count) begin
          failures++; $display("FAIL flush_after got busy=%b rv=%b cnt=%0d exp 0 0 %0d", busy, res_valid, issue_count, m_count); end
      end
    end
    req_op[0] = OP_ADD;
  endtask

  task automatic test_async_reset();
    res_t e;
    int   w;
    @(negedge clk);
    req_valid = 4'b0010; res_ready = 1'b0;
    #1;
    w = pick(m_last, req_valid);
    checks++; if (req_ready !== onehot(w)) begin failures++; $display("FAIL ar_grant got=%b exp=%b", req_ready, onehot(w)); end
    if (w >= 0) model_grant(w);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++; if (res_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL ar_resp got rv=%b busy=%b exp 1 1", res_valid, busy); end
    #2;
    rst = 1'b1; req_valid = 4'b1111;
    #1;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000 || issue_count !== 16'h0000) begin
      failures++; $display("FAIL ar_async got rv=%b busy=%b ready=%b cnt=%0d exp 0 0 0000 0", res_valid, busy, req_ready, issue_count); end
    @(negedge clk);
    rst = 1'b0; req_valid = 4'b0000; m_last = N - 1; m_count = 16'h0000; exp_q.delete();
    @(negedge clk);
    req_valid = 4'b1111; res_ready = 1'b1;
    #1;
    w = pick(m_last, req_valid);
    checks++; if (req_ready !== onehot(w)) begin failures++; $display("FAIL ar_first_grant got=%b exp=%b", req_ready, onehot(w)); end
    if (w >= 0) model_grant(w);
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    e = exp_q.pop_front();
    checks++; if (res_valid !== 1'b1 || alu_op !== e.op || alu_warp !== e.warp) begin
      failures++; $display("FAIL ar_result got rv=%b op=%h warp=%0d exp 1 op=%h warp=%0d", res_valid, alu_op, alu_warp, e.op, e.warp); end
    @(negedge clk);
  endtask

  task automatic test_count_wrap();
    int k;
    @(negedge clk);
    req_valid = 4'b0001; res_ready = 1'b1;
    k = 32'hFFFF - int'(m_count);
    repeat (k) @(posedge clk);
    m_count = m_count + 16'(k);
    m_last  = 0;
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++; if (issue_count !== m_count) begin failures++; $display("FAIL wrap_max got=%h exp=%h", issue_count, m_count); end
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== onehot(pick(m_last, req_valid))) begin
      failures++; $display("FAIL wrap_grant got=%b exp=%b", req_ready, onehot(pick(m_last, req_valid))); end
    m_count = m_count + 16'd1;
    @(negedge clk);
    req_valid = 4'b0000;
    #1;
    checks++; if (issue_count !== 16'h0000) begin failures++; $display("FAIL wrap_zero got=%h exp=0000", issue_count); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_idiv();
    test_stall();
    test_flush();
    test_async_reset();
    test_count_wrap();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
